// File: rtl/sale_terminal_pkg.sv
// Shared constants, types and the price table for the sale terminal basket.
package sale_terminal_pkg;

  localparam int NUM_PRODUCTS = 12;
  localparam int BASKET_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    WRITE,
    TOTAL,
    DONE
  } state_t;

  // Latched add/remove request; qty == 0 means remove.
  typedef struct packed {
    logic [3:0] pid;
    logic [3:0] qty;
  } basket_req_t;

  // Price(id) = 10*(id+1); entry 0 is the rightmost element.
  localparam logic [11:0][7:0] PRICE_TABLE = {
    8'd120, 8'd110, 8'd100, 8'd90, 8'd80, 8'd70,
    8'd60,  8'd50,  8'd40,  8'd30, 8'd20, 8'd10
  };

  // Quantity add clamped at 15 so a slot never wraps.
  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

endpackage

// File: rtl/basket_controller_price_rom.sv
// Combinational price lookup; unknown product IDs cost nothing.
module price_rom
  import sale_terminal_pkg::*;
(
  input  logic [3:0] id,
  output logic [7:0] price
);

  // Table read guarded against IDs past the catalogue.
  always_comb begin
    price = '0;
    if (id < 4'(NUM_PRODUCTS)) price = PRICE_TABLE[id];
  end

endmodule

// File: rtl/basket_controller.sv
// Shopping basket: sequential slot search, single-cycle update, then a
// slot-by-slot recompute of item count and total price.
module basket_controller
  import sale_terminal_pkg::*;
#(
  parameter int BASKET_DEPTH = sale_terminal_pkg::BASKET_DEPTH,
  parameter int NUM_PRODUCTS = sale_terminal_pkg::NUM_PRODUCTS
)(
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        Enable_Pulse,
  input  logic [3:0]  ProductID_in,
  input  logic [3:0]  Quantity_in,
  input  logic        Clear_Pulse,
  input  logic [2:0]  Rd_Index,
  output logic        Rd_Valid,
  output logic [3:0]  Rd_ProductID,
  output logic [3:0]  Rd_Quantity,
  output logic        Busy,
  output logic        Done_Pulse,
  output logic        Error_Full,
  output logic        Error_InvalidID,
  output logic [3:0]  ItemCount,
  output logic [15:0] TotalPrice
);

  localparam int IDX_W = (BASKET_DEPTH > 1) ? $clog2(BASKET_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BASKET_DEPTH - 1);

  state_t                        state, state_nx;
  basket_req_t                   req;
  logic [IDX_W-1:0]              idx;
  logic [BASKET_DEPTH-1:0]       slot_vld;
  logic [BASKET_DEPTH-1:0][3:0]  slot_pid;
  logic [BASKET_DEPTH-1:0][3:0]  slot_qty;
  logic                          hit, free_seen;
  logic [IDX_W-1:0]              hit_idx, free_idx;
  logic [15:0]                   acc;
  logic [3:0]                    cnt;
  logic                          full_q, inv_q, clr_q;
  logic                          busy, done;
  logic [7:0]                    price;
  logic [11:0]                   term;
  logic                          id_ok, req_ok, cur_vld, cur_hit, is_full;

  // Clear beats a same-cycle Enable; requests only count in IDLE.
  assign id_ok   = {1'b0, ProductID_in} < 5'(NUM_PRODUCTS);
  assign req_ok  = Enable_Pulse && !Clear_Pulse && id_ok;
  assign cur_vld = slot_vld[idx];
  assign cur_hit = cur_vld && (slot_pid[idx] == req.pid);
  // Decided in WRITE from the registered scan results (covers the last slot).
  assign is_full = !hit && (req.qty != 4'd0) && !free_seen;

  price_rom u_price (
    .id    (slot_pid[idx]),
    .price (price)
  );

  // 4b x 8b fits 12b; 8 slots of at most 3825 fit the 16b accumulator.
  assign term = 12'(slot_qty[idx]) * 12'(price);

  // State register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: full basket visits WRITE without writing and skips TOTAL.
  always_comb begin
    state_nx = state;
    if (Clear_Pulse) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (req_ok) state_nx = SEARCH;
        SEARCH:  if (idx == LAST_IDX) state_nx = WRITE;
        WRITE:   state_nx = is_full ? DONE : TOTAL;
        TOTAL:   if (idx == LAST_IDX) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Status outputs; a clear reports completion in the following cycle.
  always_comb begin
    busy = (state == SEARCH) || (state == WRITE) || (state == TOTAL);
    done = (state == DONE) || clr_q;
  end

  assign Busy            = busy;
  assign Done_Pulse      = done;
  assign Error_Full      = (state == DONE) && full_q;
  assign Error_InvalidID = inv_q;

  // Request latch, scan bookkeeping, accumulation and published totals.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      req        <= '0;
      idx        <= '0;
      hit        <= 1'b0;
      free_seen  <= 1'b0;
      hit_idx    <= '0;
      free_idx   <= '0;
      acc        <= '0;
      cnt        <= '0;
      full_q     <= 1'b0;
      inv_q      <= 1'b0;
      clr_q      <= 1'b0;
      ItemCount  <= '0;
      TotalPrice <= '0;
    end else begin
      inv_q  <= (state == IDLE) && Enable_Pulse && !Clear_Pulse && !id_ok;
      clr_q  <= Clear_Pulse;
      full_q <= 1'b0;
      if (Clear_Pulse) begin
        idx        <= '0;
        acc        <= '0;
        cnt        <= '0;
        ItemCount  <= '0;
        TotalPrice <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (req_ok) begin
              req       <= '{pid: ProductID_in, qty: Quantity_in};
              idx       <= '0;
              hit       <= 1'b0;
              free_seen <= 1'b0;
            end
          end
          SEARCH: begin
            if (cur_hit && !hit) begin
              hit     <= 1'b1;
              hit_idx <= idx;
            end
            if (!cur_vld && !free_seen) begin
              free_seen <= 1'b1;
              free_idx  <= idx;
            end
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          end
          WRITE: begin
            full_q <= is_full;
            idx    <= '0;
            acc    <= '0;
            cnt    <= '0;
          end
          TOTAL: begin
            if (cur_vld) begin
              acc <= acc + 16'(term);
              cnt <= cnt + 4'd1;
            end
            if (idx == LAST_IDX) begin
              TotalPrice <= acc + (cur_vld ? 16'(term) : 16'd0);
              ItemCount  <= cnt + 4'(cur_vld);
            end
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Slot valid bits: the only slot state that needs a reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) slot_vld <= '0;
    else if (Clear_Pulse) slot_vld <= '0;
    else if (state == WRITE && !is_full) begin
      if (hit) begin
        if (req.qty == 4'd0) slot_vld[hit_idx] <= 1'b0;
      end else if (req.qty != 4'd0) begin
        slot_vld[free_idx] <= 1'b1;
      end
    end
  end

  // Slot payload; meaningless while the valid bit is low, so no reset.
  always_ff @(posedge CLOCK_50) begin
    if (!Clear_Pulse && state == WRITE && req.qty != 4'd0) begin
      if (hit) begin
        slot_qty[hit_idx] <= sat_add(slot_qty[hit_idx], req.qty);
      end else if (free_seen) begin
        slot_pid[free_idx] <= req.pid;
        slot_qty[free_idx] <= req.qty;
      end
    end
  end

  // Display read port, masked to zero on empty slots.
  assign Rd_Valid     = slot_vld[Rd_Index];
  assign Rd_ProductID = Rd_Valid ? slot_pid[Rd_Index] : 4'd0;
  assign Rd_Quantity  = Rd_Valid ? slot_qty[Rd_Index] : 4'd0;

endmodule

// File: tb/tb_basket_controller.sv
// Directed bench for basket_controller with hand-computed expectations.
module tb_basket_controller;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        Enable_Pulse = 1'b0;
  logic [3:0]  ProductID_in = '0;
  logic [3:0]  Quantity_in = '0;
  logic        Clear_Pulse = 1'b0;
  logic [2:0]  Rd_Index = '0;
  logic        Rd_Valid;
  logic [3:0]  Rd_ProductID;
  logic [3:0]  Rd_Quantity;
  logic        Busy;
  logic        Done_Pulse;
  logic        Error_Full;
  logic        Error_InvalidID;
  logic [3:0]  ItemCount;
  logic [15:0] TotalPrice;

  int errs = 0;
  int checks = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  basket_controller dut (
    .CLOCK_50        (CLOCK_50),
    .RESET_N         (RESET_N),
    .Enable_Pulse    (Enable_Pulse),
    .ProductID_in    (ProductID_in),
    .Quantity_in     (Quantity_in),
    .Clear_Pulse     (Clear_Pulse),
    .Rd_Index        (Rd_Index),
    .Rd_Valid        (Rd_Valid),
    .Rd_ProductID    (Rd_ProductID),
    .Rd_Quantity     (Rd_Quantity),
    .Busy            (Busy),
    .Done_Pulse      (Done_Pulse),
    .Error_Full      (Error_Full),
    .Error_InvalidID (Error_InvalidID),
    .ItemCount       (ItemCount),
    .TotalPrice      (TotalPrice)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic slot(input string tag, input int i, input int v, input int p, input int q);
    Rd_Index = 3'(i);
    #1;
    chk({tag, ".valid"}, int'(Rd_Valid), v);
    chk({tag, ".pid"},   int'(Rd_ProductID), p);
    chk({tag, ".qty"},   int'(Rd_Quantity), q);
  endtask

  task automatic totals(input string tag, input int n, input int price);
    chk({tag, ".count"}, int'(ItemCount), n);
    chk({tag, ".total"}, int'(TotalPrice), price);
  endtask

  // Issue one request; cycle 1 is the one right after the sampling edge.
  task automatic op(input string tag, input int pid, input int qty, input int lat, input int full);
    int c;
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b1; ProductID_in = 4'(pid); Quantity_in = 4'(qty);
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b0;
    c = 1;
    chk({tag, ".busy"}, int'(Busy), 1);
    while (!Done_Pulse && c < 40) begin
      @(negedge CLOCK_50);
      c++;
    end
    chk({tag, ".lat"}, c, lat);
    chk({tag, ".full"}, int'(Error_Full), full);
    chk({tag, ".busy_done"}, int'(Busy), 0);
  endtask

  // Start a request and stop in the middle of cycle n of the operation.
  task automatic start_to(input int pid, input int qty, input int n);
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b1; ProductID_in = 4'(pid); Quantity_in = 4'(qty);
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b0;
    for (int k = 1; k < n; k++) @(negedge CLOCK_50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nd, nb;
    // Reset state
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst.busy", int'(Busy), 0);
    chk("rst.done", int'(Done_Pulse), 0);
    chk("rst.efull", int'(Error_Full), 0);
    chk("rst.einv", int'(Error_InvalidID), 0);
    totals("rst", 0, 0);
    slot("rst.s0", 0, 0, 0, 0);
    RESET_N = 1'b1;

    // First add: price(3)=40, 2*40
    op("add3", 3, 2, 18, 0);
    totals("add3", 1, 80);
    slot("add3.s0", 0, 1, 3, 2);

    // Saturating add: 2+14 -> 15, 15*40
    op("sat3", 3, 14, 18, 0);
    totals("sat3", 1, 600);
    slot("sat3.s0", 0, 1, 3, 15);

    // Second product into slot 1: 600+60
    op("add5", 5, 1, 18, 0);
    totals("add5", 2, 660);
    slot("add5.s1", 1, 1, 5, 1);

    // Remove product 3
    op("rm3", 3, 0, 18, 0);
    totals("rm3", 1, 60);
    slot("rm3.s0", 0, 0, 0, 0);

    // Freed slot 0 reused: 60 + 2*80
    op("add7", 7, 2, 18, 0);
    totals("add7", 2, 220);
    slot("add7.s0", 0, 1, 7, 2);

    // Invalid product ID
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b1; ProductID_in = 4'd12; Quantity_in = 4'd1;
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b0;
    chk("inv.flag", int'(Error_InvalidID), 1);
    chk("inv.busy", int'(Busy), 0);
    @(negedge CLOCK_50);
    chk("inv.flag_end", int'(Error_InvalidID), 0);
    chk("inv.busy2", int'(Busy), 0);
    totals("inv", 2, 220);

    // Fill slots 2..7: adds 10+20+30+40+50+70
    op("f0", 0, 1, 18, 0);
    op("f1", 1, 1, 18, 0);
    op("f2", 2, 1, 18, 0);
    op("f3", 3, 1, 18, 0);
    op("f4", 4, 1, 18, 0);
    op("f6", 6, 1, 18, 0);
    totals("fill", 8, 440);

    // Full basket rejects a new product
    op("full9", 9, 1, 10, 1);
    totals("full9", 8, 440);
    slot("full9.s7", 7, 1, 6, 1);
    @(negedge CLOCK_50);
    chk("full9.efull_end", int'(Error_Full), 0);
    chk("full9.done_end", int'(Done_Pulse), 0);

    // Enable during Busy is dropped: only product 0 increments (+10)
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b1; ProductID_in = 4'd0; Quantity_in = 4'd1;
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b1; ProductID_in = 4'd1; Quantity_in = 4'd5;
    @(negedge CLOCK_50);
    Enable_Pulse = 1'b0;
    nd = 4;
    while (!Done_Pulse && nd < 40) begin
      @(negedge CLOCK_50);
      nd++;
    end
    chk("busyen.lat", nd, 18);
    nb = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLOCK_50);
      if (Busy) nb++;
    end
    chk("busyen.no_second", nb, 0);
    totals("busyen", 8, 450);
    slot("busyen.s2", 2, 1, 0, 2);
    slot("busyen.s3", 3, 1, 1, 1);

    // Clear in the 5th SEARCH cycle aborts and empties
    start_to(2, 1, 5);
    chk("clr.busy_before", int'(Busy), 1);
    Clear_Pulse = 1'b1;
    @(negedge CLOCK_50);
    Clear_Pulse = 1'b0;
    chk("clr.done", int'(Done_Pulse), 1);
    chk("clr.busy", int'(Busy), 0);
    totals("clr", 0, 0);
    slot("clr.s0", 0, 0, 0, 0);
    @(negedge CLOCK_50);
    chk("clr.done_end", int'(Done_Pulse), 0);

    // Clear and Enable together: Clear wins
    op("pre", 2, 3, 18, 0);
    totals("pre", 1, 90);
    @(negedge CLOCK_50);
    Clear_Pulse = 1'b1; Enable_Pulse = 1'b1; ProductID_in = 4'd4; Quantity_in = 4'd1;
    @(negedge CLOCK_50);
    Clear_Pulse = 1'b0; Enable_Pulse = 1'b0;
    chk("both.done", int'(Done_Pulse), 1);
    chk("both.busy", int'(Busy), 0);
    totals("both", 0, 0);
    nd = 0; nb = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLOCK_50);
      if (Done_Pulse) nd++;
      if (Busy) nb++;
    end
    chk("both.no_done", nd, 0);
    chk("both.no_busy", nb, 0);
    totals("both_end", 0, 0);
    slot("both.s0", 0, 0, 0, 0);

    // Reset mid-operation: no completion strobe afterwards
    start_to(4, 1, 5);
    RESET_N = 1'b0;
    #1;
    chk("rstmid.busy", int'(Busy), 0);
    chk("rstmid.done", int'(Done_Pulse), 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLOCK_50);
      if (Done_Pulse) nd++;
    end
    chk("rstmid.no_done", nd, 0);
    totals("rstmid", 0, 0);
    slot("rstmid.s0", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/basket_controller.md
BASKET_CONTROLLER -- requirements
Module: basket_controller

Interface
REQ-001 Parameter BASKET_DEPTH, default 8: number of basket slots.
REQ-002 Parameter NUM_PRODUCTS, default 12: valid product IDs are 0..NUM_PRODUCTS-1.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- CLOCK_50 in 1: sole clock; all state changes on its rising edge.
- RESET_N in 1: asynchronous, active-low reset.
- Enable_Pulse in 1: one-cycle add/remove request.
- ProductID_in in 4: product for the request.
- Quantity_in in 4: 1..15 adds that quantity; 0 removes the product.
- Clear_Pulse in 1: one-cycle empty-basket request.
- Rd_Index in 3: display read slot.
- Rd_Valid out 1: slot Rd_Index occupied, combinational from registers.
- Rd_ProductID out 4: product ID in slot Rd_Index, combinational from registers.
- Rd_Quantity out 4: quantity in slot Rd_Index, combinational from registers.
- Busy out 1: high while an operation is in progress.
- Done_Pulse out 1: one-cycle completion strobe.
- Error_Full out 1: one-cycle strobe, request rejected because the basket is full.
- Error_InvalidID out 1: one-cycle strobe, ProductID_in >= NUM_PRODUCTS.
- ItemCount out 4: number of occupied slots.
- TotalPrice out 16: sum over occupied slots of quantity*price.

Function
REQ-004 States SHALL be IDLE, SEARCH, WRITE, TOTAL and DONE.
REQ-005 In IDLE, Enable_Pulse with a valid ID SHALL latch ID and quantity, raise Busy and enter SEARCH; requests are accepted only in IDLE.
REQ-006 In IDLE, Enable_Pulse with an invalid ID SHALL pulse Error_InvalidID in the next cycle, stay in IDLE and leave the basket unchanged.
REQ-007 SEARCH SHALL scan slots 0..BASKET_DEPTH-1, one per cycle, always all slots, recording the first matching occupied slot and the first free slot.
REQ-008 WRITE (1 cycle) SHALL apply the request:
- match and qty>0: quantity = min(old+qty, 15);
- match and qty=0: clear the valid bit;
- no match and qty>0: fill the first free slot;
- no match and qty=0: no change.
REQ-009 No match, qty>0 and no free slot SHALL skip WRITE and TOTAL, go to DONE, and pulse Error_Full together with Done_Pulse.
REQ-010 TOTAL SHALL accumulate quantity*price one slot per cycle (BASKET_DEPTH cycles), and SHALL update TotalPrice and ItemCount only on exit.
REQ-011 Arithmetic: the 4b x 8b product is 12b and the accumulator is 16b. The maximum sum 8*15*255=30600 SHALL NOT overflow.
REQ-012 DONE SHALL last 1 cycle with Done_Pulse=1 and Busy=0, then return to IDLE.
REQ-013 Latency with BASKET_DEPTH=8, counted from the edge sampling Enable_Pulse: Done_Pulse SHALL be high in cycle +18 (normal) and cycle +10 (full error).
REQ-014 Enable_Pulse while Busy SHALL be ignored with no flag.
REQ-015 Clear_Pulse in any state SHALL invalidate all slots, zero TotalPrice and ItemCount, abort any operation, return to IDLE next cycle, and pulse Done_Pulse once.
REQ-016 When Clear_Pulse and Enable_Pulse arrive in the same cycle, Clear SHALL win and Enable SHALL be dropped.
REQ-017 Rd_* SHALL reflect register contents, and SHALL be updated the cycle after WRITE.

Reset
REQ-018 RESET_N low SHALL immediately force:
- state IDLE and all valid bits 0;
- Busy=0, Done_Pulse=0, Error_Full=0, Error_InvalidID=0;
- ItemCount=0 and TotalPrice=0.
REQ-019 Slot contents need not reset; Rd_ProductID and Rd_Quantity SHALL be 0 whenever Rd_Valid=0.
REQ-020 Reset asserted mid-operation SHALL discard the operation with no Done_Pulse.

Structure
REQ-021 The shared package sale_terminal_pkg SHALL hold NUM_PRODUCTS, BASKET_DEPTH, the state encoding and the 12-entry 8-bit price table. Price(id) = 10*(id+1) for ids 0..11.
REQ-022 Price lookup SHALL be one sub-module, price_rom (combinational, 4b ID in, 8b price out, 0 for ids >= 12).

Verification
REQ-023 After reset, add ID 3 qty 2 -> Done_Pulse at +18, ItemCount=1, TotalPrice=80, slot0 = {1,3,2}.
REQ-024 Add ID 3 qty 14 on top of the previous case -> quantity saturates at 15, TotalPrice=600.
REQ-025 Fill 8 distinct IDs, then add ID 9 -> Error_Full and Done_Pulse at +10, basket unchanged.
REQ-026 Remove ID 3 (qty 0) from a 2-item basket -> slot invalid, ItemCount=1, the freed slot is reused by the next add.
REQ-027 Enable with ID 12 -> Error_InvalidID next cycle, Busy never asserted.
REQ-028 Clear_Pulse in the 5th SEARCH cycle, with a simultaneous Enable in IDLE on the next try -> basket empty, TotalPrice=0, the Enable dropped.
